// File: rtl/rca_sweep_checker_if.sv
// -----------------------------------------------------------------------------
// rca_sweep_checker_if
// Operand/result bus between the sweep checker and the ripple-carry adder
// under test.
//   a, b  : WIDTH-bit operands driven by the checker
//   cin   : carry-in driven by the checker
//   sum   : WIDTH-bit result driven by the adder (combinational)
//   cout  : carry-out driven by the adder (combinational)
// The master modport is the checker side and the slave modport is the adder side.
// -----------------------------------------------------------------------------
interface rca_sweep_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout
    );
endinterface

// File: rtl/rca_sweep_checker.sv
// -----------------------------------------------------------------------------
// rca_sweep_checker
// Exhaustive self-checking harness for a WIDTH-bit ripple-carry adder. The
// checker walks every {cin, a, b} combination, with b innermost and cin
// outermost. It holds each vector for SETTLE cycles and then compares the
// adder result against a golden a+b+cin. The checker counts mismatches and
// captures the operands of the first failing vector.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          one-cycle pulse; begins a sweep from IDLE or DONE
//   bus            master side of the adder bus (a, b, cin out; sum, cout in)
//   busy           sweep in progress
//   done           sweep finished; held until the next start or reset
//   pass           valid while done=1; high iff err_count==0
//   err_count      number of mismatching vectors (2*WIDTH+2 bits)
//   first_err_a    A operand of the first mismatch
//   first_err_b    B operand of the first mismatch
//   first_err_cin  cin of the first mismatch
// -----------------------------------------------------------------------------
module rca_sweep_checker #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    rca_sweep_checker_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2*WIDTH+1:0]     err_count,
    output logic [WIDTH-1:0]       first_err_a,
    output logic [WIDTH-1:0]       first_err_b,
    output logic                   first_err_cin
);

    localparam int VW = 2 * WIDTH + 1;                    // {cin, a, b} vector width
    localparam int EW = 2 * WIDTH + 2;                    // error counter width
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [SW-1:0]    settle_r;

    logic [WIDTH:0]   golden_s;
    logic             mismatch_s;
    logic             sample_s;
    logic             last_s;
    logic [VW-1:0]    vec_next_s;
    logic [EW-1:0]    err_next_s;

    // Reference sum: operands zero-extended to WIDTH+1 so the carry-out lands in the MSB
    function automatic logic [WIDTH:0] golden_sum(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Compare, last-vector detect and next-vector/next-count arithmetic
    always_comb begin
        golden_s   = golden_sum(bus.a, bus.b, bus.cin);
        mismatch_s = ({bus.cout, bus.sum} != golden_s);
        sample_s   = (settle_r == SETTLE_LAST);
        last_s     = bus.cin & (&bus.a) & (&bus.b);
        // b carries into a, and a carries into cin, because they are one concatenated counter
        vec_next_s = {bus.cin, bus.a, bus.b} + VW'(1'b1);
        if (mismatch_s) begin
            err_next_s = err_count + EW'(1'b1);
        end else begin
            err_next_s = err_count;
        end
    end

    // Sweep FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            settle_r      <= '0;
            bus.a         <= '0;
            bus.b         <= '0;
            bus.cin       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_cin <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r       <= RUN;
                        settle_r      <= '0;
                        bus.a         <= '0;
                        bus.b         <= '0;
                        bus.cin       <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_a   <= '0;
                        first_err_b   <= '0;
                        first_err_cin <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here, so a running sweep cannot be restarted
                    if (sample_s) begin
                        settle_r  <= '0;
                        err_count <= err_next_s;
                        // err_count is still zero only before the first mismatch of this sweep
                        if (mismatch_s && (err_count == '0)) begin
                            first_err_a   <= bus.a;
                            first_err_b   <= bus.b;
                            first_err_cin <= bus.cin;
                        end
                        if (last_s) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next_s == '0);
                            bus.a   <= '0;
                            bus.b   <= '0;
                            bus.cin <= 1'b0;
                        end else begin
                            {bus.cin, bus.a, bus.b} <= vec_next_s;
                        end
                    end else begin
                        settle_r <= settle_r + SW'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_rca_sweep_checker
// The bench runs the sweep checker against a behavioural adder with
// selectable fault injection. The stimulus process chooses a fault mode,
// derives the expected sweep outcome by enumerating every vector, and pushes
// that outcome into a scoreboard queue. A monitor running on the falling edge
// checks several things:
//   - the operand sequence and busy while a sweep is active,
//   - done timing,
//   - err_count, pass and first_err when done rises.
// -----------------------------------------------------------------------------
module tb_rca_sweep_checker;

    localparam int W      = 3;
    localparam int SETTLE = 2;
    localparam int N      = 1 << (2 * W + 1);
    localparam int M      = (1 << W) - 1;

    typedef struct {
        int errs;
        int fa;
        int fb;
        int fc;
        int start_edge;
        int done_cycle;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic pass;
    logic [2*W+1:0] err_count;
    logic [W-1:0]   first_err_a;
    logic [W-1:0]   first_err_b;
    logic           first_err_cin;

    int   checks;
    int   errors;
    int   cyc;
    int   fault_mode;
    int   fault_vec;
    exp_t exp_q[$];
    exp_t mon_e;
    logic done_prev;

    rca_sweep_checker_if #(.WIDTH(W)) ifc ();

    rca_sweep_checker #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (ifc.master),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_a   (first_err_a),
        .first_err_b   (first_err_b),
        .first_err_cin (first_err_cin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test. Modes: 0 correct, 1 sum[0] stuck at 0, 2 cout stuck
    // at 0, 3 sum forced to 0 at vector index fault_vec, 4 sum[0] inverted
    // for every vector index >= fault_vec.
    function automatic int adder_out(input int mode, input int fv,
                                     input int av, input int bv, input int cv);
        int idx;
        int r;
        idx = (cv << (2 * W)) | (av << W) | bv;
        r   = av + bv + cv;
        case (mode)
            1:       r = r & ~1;
            2:       r = r & M;
            3:       if (idx == fv) r = r & (1 << W);
            4:       if (idx >= fv) r = r ^ 1;
            default: r = r;
        endcase
        return r;
    endfunction

    always_comb begin
        int r;
        r = adder_out(fault_mode, fault_vec, int'(ifc.a), int'(ifc.b), int'(ifc.cin));
        ifc.sum  = r[W-1:0];
        ifc.cout = r[W];
    end

    // Reference: enumerate every vector in sweep order and compare the adder against true a+b+cin
    task automatic model(input int mode, input int fv, output int errs,
                         output int fa, output int fb, output int fc);
        errs = 0; fa = 0; fb = 0; fc = 0;
        for (int k = 0; k < N; k++) begin
            int av, bv, cv;
            cv = k >> (2 * W);
            av = (k >> W) & M;
            bv = k & M;
            if (adder_out(mode, fv, av, bv, cv) != av + bv + cv) begin
                if (errs == 0) begin
                    fa = av; fb = bv; fc = cv;
                end
                errs++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: check the sweep while it is active, and check the scoreboard entry when done rises
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q[0];
            if (cyc >= mon_e.start_edge && cyc < mon_e.done_cycle) begin
                chk("busy_during_sweep", int'(busy), 1);
                chk("vector_order", int'({ifc.cin, ifc.a, ifc.b}),
                    (cyc - mon_e.start_edge) / SETTLE);
            end
        end
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("done_without_sweep", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_timing",   cyc, mon_e.done_cycle);
                chk("err_count",     int'(err_count), mon_e.errs);
                chk("pass",          int'(pass), int'(mon_e.errs == 0));
                chk("first_err_a",   int'(first_err_a), mon_e.fa);
                chk("first_err_b",   int'(first_err_b), mon_e.fb);
                chk("first_err_cin", int'(first_err_cin), mon_e.fc);
                chk("busy_at_done",  int'(busy), 0);
                chk("operands_cleared", int'({ifc.cin, ifc.a, ifc.b}), 0);
            end
        end
        done_prev <= done;
    end

    task automatic check_idle_reset(input string tag);
        chk({tag, "_a_b_cin"}, int'({ifc.cin, ifc.a, ifc.b}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_first_err"}, int'({first_err_cin, first_err_a, first_err_b}), 0);
    endtask

    // disturb: 0 none, 1 spurious start pulse about 10 cycles in, 2 reset about 20 cycles in
    task automatic run_sweep(input int mode, input int fv, input int disturb);
        exp_t e;
        @(negedge clk);
        fault_mode = mode;
        fault_vec  = fv;
        model(mode, fv, e.errs, e.fa, e.fb, e.fc);
        e.start_edge = cyc + 1;
        e.done_cycle = e.start_edge + N * SETTLE;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb == 1) begin
            repeat (9) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (disturb == 2) begin
            repeat (19) @(negedge clk);
            rst = 1'b1;
            exp_q.delete();
            #1;
            check_idle_reset("midsweep_reset");
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int i = 0; i < N * SETTLE + 20 && exp_q.size() > 0; i++) @(negedge clk);
            chk("sweep_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        fault_mode = 0;
        fault_vec  = 0;
        done_prev  = 1'b0;
        start      = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 0, 0);                 // correct adder
        repeat (5) @(negedge clk);
        chk("done_held", int'(done), 1);
        chk("pass_held", int'(pass), 1);
        run_sweep(0, 0, 0);                 // restart from DONE
        run_sweep(1, 0, 0);                 // sum[0] stuck at 0
        run_sweep(2, 0, 0);                 // cout stuck at 0
        run_sweep(0, 0, 0);                 // restart from DONE must clear the previous errors
        run_sweep(3, N - 1, 0);             // fault only on the last vector
        run_sweep(3, 1, 0);                 // fault only on the second vector
        run_sweep(0, 0, 1);                 // a start during RUN is ignored
        run_sweep(1, 0, 2);                 // reset in the middle of a sweep
        run_sweep(0, 0, 0);                 // a fresh start after reset gives a full sweep
        for (int s = 0; s < 8; s++) begin
            run_sweep(int'($urandom_range(0, 4)), int'($urandom_range(0, N - 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_sweep_checker.md
Name: rca_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around the ripple-carry adder.
- Upstream: walks every {cin, a, b} combination in a fixed order and drives the adder operand inputs.
- Downstream: samples the adder's sum/cout, compares them against an internal golden a+b+cin, and counts mismatches.
- Captures the first failing vector and raises done/pass, so adder sign-off needs no hand-written vector list.

Parameters:
- WIDTH, 8, operand width; must match the adder under test.
- SETTLE, 1, cycles each vector is held before its result is sampled (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a sweep.
- a  output  WIDTH  operand A to the adder.
- b  output  WIDTH  operand B to the adder.
- cin  output  1  carry-in to the adder.
- sum  input  WIDTH  adder sum result.
- cout  input  1  adder carry-out.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start or reset.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  2*WIDTH+2  number of mismatching vectors.
- first_err_a  output  WIDTH  A operand of the first mismatch.
- first_err_b  output  WIDTH  B operand of the first mismatch.
- first_err_cin  output  1  cin of the first mismatch.

Behaviour:
- Reset (async, any state): state=IDLE; a, b, cin = 0; busy, done, pass = 0; err_count = 0; first_err_* = 0; settle counter = 0.
- Sweep order, N = 2^(2*WIDTH+1) vectors:
  - b is the innermost counter, then a, then cin outermost.
  - Sequence: (cin0,a0,b0), (cin0,a0,b1) … (cin0,a0,bMAX), (cin0,a1,b0) … (cin1,aMAX,bMAX).
  - b wraps MAX->0 with a carry into a; a wraps with a carry into cin.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - On that edge: a, b, cin = 0; err_count = 0; first_err_* = 0; done = 0; pass = 0; busy = 1; settle counter = 0.
- RUN:
  - Operands stay constant for SETTLE cycles.
  - On the edge where the settle counter reaches SETTLE-1, sample {cout, sum} and compare with the golden value {exp_cout, exp_sum} = a + b + cin, computed WIDTH+1 bits wide with zero extension.
  - On a mismatch, increment err_count. If this is the first mismatch of the sweep, load first_err_* with the current operands in the same edge.
  - On that same edge, advance to the next vector and reset the settle counter.
  - If the sampled vector was the last one (cin=1, a=MAX, b=MAX): go to DONE instead of advancing. Set busy=0, done=1, pass = (final err_count==0), including any mismatch on the last vector. Reset a, b, cin to 0.
- Timing:
  - The start edge presents vector 0.
  - Vector k is sampled at edge start + (k+1)*SETTLE.
  - done rises at edge start + N*SETTLE.
- DONE: outputs hold. start=1 behaves exactly as from IDLE: counters clear and a new sweep begins.
- start while in RUN: ignored; the sweep is not restarted.
- err_count cannot overflow: its width covers N exactly. No saturation logic is required.
- sum and cout are treated as combinational inputs; the block never samples them earlier than SETTLE cycles after an operand change.
- Reset asserted mid-sweep: all state clears immediately; done stays 0; a later start restarts from vector 0.

Test Plan:
- Correct adder, WIDTH=8, SETTLE=1: pulse start -> busy=1 for 131072 cycles; done=1 at start+131072; pass=1; err_count=0; first_err_* = 0.
- Adder with sum[0] forced to 0, WIDTH=8 -> err_count=65536; pass=0; first_err = (a=0, b=1, cin=0).
- Adder with cout forced to 0, WIDTH=8 -> err_count=65536 (32640 with cin=0 plus 32896 with cin=1); first_err = (a=1, b=255, cin=0).
- WIDTH=2, SETTLE=3, correct adder -> 32 vectors; each operand held exactly 3 cycles; done at start+96; pass=1; second start after done clears err_count and repeats.
- WIDTH=2, correct adder: pulse start again at cycle 10 of the sweep -> ignored; done still at start+32. Separate run: assert rst at cycle 20 -> a=b=cin=0, busy=0, done=0 immediately; a fresh start yields a full 32-vector sweep.
- WIDTH=2, adder with sum forced to 0 only at a=3, b=3, cin=1 (the last vector) -> err_count=1; pass=0 on the done cycle; first_err = (3, 3, 1).
